rx_ptr_rd_arb: RTL and testbench

Two-requester, round-robin read arbiter that shares the single read port of the RX tail-pointer table among the RX engine and the app-side receive path. It sits between the requesters and the table. It records the owner of each granted read in an in-order tag FIFO, so every response returns to the requester that issued it. Requests pass through combinationally, so the arbiter adds no latency on the table's own read path.

---
 rtl/rx_ptr_rd_arb_if.sv | 51 +++++
 rtl/rx_ptr_rd_arb.sv | 104 ++++++++++
 tb/tb_rx_ptr_rd_arb.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_ptr_rd_arb_if.sv
// Interface bundle for the RX tail-pointer table read arbiter.
// It groups two requester channels (request and response) and the table
// read port. The master modport is the arbiter's view. The slave modport
// is the view of the surrounding requesters and the table.
interface rx_ptr_rd_arb_if #(
    parameter int FLOWID_W = 12,
    parameter int DATA_W   = 16
);
    logic                req0_val;
    logic [FLOWID_W-1:0] req0_addr;
    logic                req0_rdy;
    logic                req1_val;
    logic [FLOWID_W-1:0] req1_addr;
    logic                req1_rdy;

    logic                resp0_val;
    logic [DATA_W-1:0]   resp0_data;
    logic                resp0_rdy;
    logic                resp1_val;
    logic [DATA_W-1:0]   resp1_data;
    logic                resp1_rdy;

    logic                mem_rd_req_val;
    logic [FLOWID_W-1:0] mem_rd_req_addr;
    logic                mem_rd_req_rdy;
    logic                mem_rd_resp_val;
    logic [DATA_W-1:0]   mem_rd_resp_data;
    logic                mem_rd_resp_rdy;

    modport master (
        input  req0_val, req0_addr, req1_val, req1_addr,
        output req0_rdy, req1_rdy,
        output resp0_val, resp0_data, resp1_val, resp1_data,
        input  resp0_rdy, resp1_rdy,
        output mem_rd_req_val, mem_rd_req_addr,
        input  mem_rd_req_rdy,
        input  mem_rd_resp_val, mem_rd_resp_data,
        output mem_rd_resp_rdy
    );

    modport slave (
        output req0_val, req0_addr, req1_val, req1_addr,
        input  req0_rdy, req1_rdy,
        input  resp0_val, resp0_data, resp1_val, resp1_data,
        output resp0_rdy, resp1_rdy,
        input  mem_rd_req_val, mem_rd_req_addr,
        output mem_rd_req_rdy,
        output mem_rd_resp_val, mem_rd_resp_data,
        input  mem_rd_resp_rdy
    );
endinterface

// File: rtl/rx_ptr_rd_arb.sv
// Two-requester round-robin read arbiter for the RX tail-pointer table.
// Requests and responses pass through combinationally. An in-order FIFO of
// 1-bit owner tags steers each table response back to the requester that
// issued the read. The table must return responses in request order.
// FLOWID_W / DATA_W defaults stand in for tcp_pkg::FLOWID_W and
// RX_PAYLOAD_PTR_W+1. Override them at instantiation.
module rx_ptr_rd_arb #(
    parameter int FLOWID_W  = 12,
    parameter int DATA_W    = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    rx_ptr_rd_arb_if.master            bus,
    output logic [$clog2(TAG_DEPTH):0] outstanding
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                 last_grant;
    logic [TAG_DEPTH-1:0] tag_fifo;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic                 full;
    logic                 empty;
    logic                 can_issue;
    logic                 sel;
    logic                 head;
    logic                 push;
    logic                 pop;
    logic [FLOWID_W-1:0]  addr_sel;
    logic [DATA_W-1:0]    resp_data;

    // Issue is gated on the registered count only, so a same-cycle pop
    // never opens a slot and the ready path stays loop-free.
    assign full      = (count == CNT_W'(TAG_DEPTH));
    assign empty     = (count == '0);
    assign can_issue = ~full;

    // Round-robin winner: a lone requester wins, and a tie goes to the one not granted last
    always_comb begin
        if (bus.req0_val && bus.req1_val) begin
            sel = ~last_grant;
        end else begin
            sel = bus.req1_val;
        end
    end

    assign addr_sel            = sel ? bus.req1_addr : bus.req0_addr;
    assign bus.mem_rd_req_addr = addr_sel;
    assign bus.mem_rd_req_val  = (bus.req0_val | bus.req1_val) & can_issue;
    assign bus.req0_rdy        = bus.mem_rd_req_rdy & can_issue & bus.req0_val & ~sel;
    assign bus.req1_rdy        = bus.mem_rd_req_rdy & can_issue & bus.req1_val & sel;

    // Response steering by the oldest outstanding tag
    assign head                = tag_fifo[rd_ptr];
    assign resp_data           = bus.mem_rd_resp_data;
    assign bus.resp0_data      = resp_data;
    assign bus.resp1_data      = resp_data;
    assign bus.resp0_val       = bus.mem_rd_resp_val & ~empty & ~head;
    assign bus.resp1_val       = bus.mem_rd_resp_val & ~empty & head;
    assign bus.mem_rd_resp_rdy = ~empty & (head ? bus.resp1_rdy : bus.resp0_rdy);

    assign push        = bus.mem_rd_req_val & bus.mem_rd_req_rdy;
    assign pop         = bus.mem_rd_resp_val & bus.mem_rd_resp_rdy;
    assign outstanding = count;

    // Pointers, occupancy and round-robin history; reset makes requester 0 win the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                last_grant <= sel;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Owner tag storage; entries are only meaningful between push and pop
    always_ff @(posedge clk) begin
        if (push) begin
            tag_fifo[wr_ptr] <= sel;
        end
    end

    // A table response with no read outstanding is a protocol error and is ignored
    a_no_resp_when_empty: assert property (@(posedge clk) disable iff (!rst)
        !(bus.mem_rd_resp_val && empty));

endmodule

// File: tb/tb_rx_ptr_rd_arb.sv
// Self-checking bench for rx_ptr_rd_arb. The reference model keeps the
// outstanding reads as a queue of owners, and keeps one queue of expected
// data per requester. A small in-order table model serves the reads.
module tb_rx_ptr_rd_arb;
    localparam int FW = 8;
    localparam int DW = 12;
    localparam int TD = 4;
    localparam int OW = $clog2(TD) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [OW-1:0] outstanding;

    rx_ptr_rd_arb_if #(.FLOWID_W(FW), .DATA_W(DW)) bus ();

    rx_ptr_rd_arb #(.FLOWID_W(FW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    bit          owners[$];
    logic [DW-1:0] tbl_q[$];
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    bit          last_g = 1'b1;
    bit          resp_en = 1'b0;
    logic [DW-1:0] next_data = '0;
    bit          m_push, m_pop, m_sel, m_head;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owners.delete();
        tbl_q.delete();
        exp_q0.delete();
        exp_q1.delete();
        last_g = 1'b1;
    endtask

    task automatic set_idle();
        bus.req0_val       = 1'b0;
        bus.req1_val       = 1'b0;
        bus.req0_addr      = '0;
        bus.req1_addr      = '0;
        bus.resp0_rdy      = 1'b1;
        bus.resp1_rdy      = 1'b1;
        bus.mem_rd_req_rdy = 1'b1;
        resp_en            = 1'b0;
    endtask

    // In-order table: offers its oldest pending read when enabled
    task automatic drive_table();
        bus.mem_rd_resp_val  = resp_en && (tbl_q.size() > 0);
        bus.mem_rd_resp_data = (tbl_q.size() > 0) ? tbl_q[0] : '0;
    endtask

    // Called on the falling edge with inputs applied: predict and compare all outputs
    task automatic settle();
        int n;
        bit full, empty, winner, any_req, granted, resp_go;
        drive_table();
        #1;
        n       = owners.size();
        full    = (n >= TD);
        empty   = (n == 0);
        any_req = bus.req0_val || bus.req1_val;
        if (bus.req0_val && bus.req1_val) winner = !last_g;
        else                              winner = bus.req1_val;
        granted = any_req && !full && bus.mem_rd_req_rdy;
        m_head  = empty ? 1'b0 : owners[0];
        resp_go = !empty && (m_head ? bus.resp1_rdy : bus.resp0_rdy);

        check("outstanding", outstanding, n);
        check("mem_req_val", bus.mem_rd_req_val, any_req && !full);
        if (any_req)
            check("mem_req_addr", bus.mem_rd_req_addr, winner ? bus.req1_addr : bus.req0_addr);
        check("req0_rdy", bus.req0_rdy, granted && !winner);
        check("req1_rdy", bus.req1_rdy, granted && winner);
        check("resp0_val", bus.resp0_val, bus.mem_rd_resp_val && !empty && !m_head);
        check("resp1_val", bus.resp1_val, bus.mem_rd_resp_val && !empty && m_head);
        check("mem_resp_rdy", bus.mem_rd_resp_rdy, resp_go);

        m_sel  = winner;
        m_push = rst && granted;
        m_pop  = rst && bus.mem_rd_resp_val && resp_go;
        if (m_pop) begin
            if (m_head) check("resp1_data", bus.resp1_data, exp_q1[0]);
            else        check("resp0_data", bus.resp0_data, exp_q0[0]);
        end
    endtask

    // Advance one clock and apply the handshakes the model predicted
    task automatic step();
        @(posedge clk);
        if (m_pop) begin
            void'(owners.pop_front());
            void'(tbl_q.pop_front());
            if (m_head) void'(exp_q1.pop_front());
            else        void'(exp_q0.pop_front());
        end
        if (m_push) begin
            owners.push_back(m_sel);
            last_g = m_sel;
            tbl_q.push_back(next_data);
            if (m_sel) exp_q1.push_back(next_data);
            else       exp_q0.push_back(next_data);
        end
        m_push = 1'b0;
        m_pop  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_idle();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        settle();
        check("rst_outstanding", outstanding, 0);
        check("rst_req_rdy", {bus.req1_rdy, bus.req0_rdy}, 0);
        check("rst_resp_val", {bus.resp1_val, bus.resp0_val}, 0);
        check("rst_mem_resp_rdy", bus.mem_rd_resp_rdy, 0);
        check("rst_mem_req_val", bus.mem_rd_req_val, 0);
        step();
        rst = 1'b1;
    endtask

    task automatic drain(input int cycles);
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
        resp_en      = 1'b1;
        bus.resp0_rdy = 1'b1;
        bus.resp1_rdy = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            settle();
            step();
        end
        check("drain_empty", outstanding, 0);
    endtask

    initial begin
        int grants;
        set_idle();
        drive_table();
        do_reset();

        // Single requester, response one cycle later
        next_data     = 12'h123;
        bus.req0_addr = 8'd5;
        bus.req0_val  = 1'b1;
        resp_en       = 1'b1;
        settle();
        check("t1_addr", bus.mem_rd_req_addr, 5);
        check("t1_rdy0", bus.req0_rdy, 1);
        step();
        bus.req0_val = 1'b0;
        settle();
        check("t1_out1", outstanding, 1);
        check("t1_resp0_val", bus.resp0_val, 1);
        check("t1_resp0_data", bus.resp0_data, 12'h123);
        check("t1_resp1_val", bus.resp1_val, 0);
        step();
        settle();
        check("t1_out0", outstanding, 0);
        step();

        // Tie after reset alternates 0,1,0,1 and responses route likewise
        do_reset();
        bus.req0_val  = 1'b1;
        bus.req0_addr = 8'd1;
        bus.req1_val  = 1'b1;
        bus.req1_addr = 8'd2;
        resp_en       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_data = DW'(12'hD0 + i);
            settle();
            check("tie_addr", bus.mem_rd_req_addr, (i % 2) ? 2 : 1);
            if (i > 0) check("tie_route", {bus.resp1_val, bus.resp0_val}, (i % 2) ? 2'b01 : 2'b10);
            step();
        end
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
        settle();
        check("tie_route_last", {bus.resp1_val, bus.resp0_val}, 2'b10);
        check("tie_data_last", bus.resp1_data, 12'hD3);
        step();

        // Full tag FIFO blocks issue until a pop has registered
        do_reset();
        bus.req0_val  = 1'b1;
        bus.req0_addr = 8'd7;
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            next_data = DW'(12'h200 + i);
            settle();
            grants += int'(bus.req0_rdy);
            step();
        end
        check("full_grants", grants, 4);
        resp_en = 1'b1;
        settle();
        check("full_rdy0", bus.req0_rdy, 0);
        check("full_out", outstanding, 4);
        check("full_pop_rdy", bus.mem_rd_resp_rdy, 1);
        step();
        resp_en   = 1'b0;
        next_data = 12'h2AA;
        settle();
        check("full_out3", outstanding, 3);
        check("full_5th_grant", bus.req0_rdy, 1);
        step();
        drain(6);

        // Response backpressure holds the head until its owner is ready
        do_reset();
        bus.req1_val  = 1'b1;
        bus.req1_addr = 8'd9;
        next_data     = 12'h3C5;
        settle();
        step();
        bus.req1_val  = 1'b0;
        resp_en       = 1'b1;
        bus.resp1_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_mem_resp_rdy", bus.mem_rd_resp_rdy, 0);
            check("bp_out", outstanding, 1);
            check("bp_data", bus.resp1_data, 12'h3C5);
            step();
        end
        bus.resp1_rdy = 1'b1;
        settle();
        check("bp_release", bus.mem_rd_resp_rdy, 1);
        step();
        settle();
        check("bp_popped", outstanding, 0);
        step();

        // Simultaneous push and pop keeps occupancy
        do_reset();
        bus.req0_val  = 1'b1;
        bus.req0_addr = 8'd3;
        for (int i = 0; i < 2; i++) begin
            next_data = DW'(12'h100 + i);
            settle();
            step();
        end
        resp_en   = 1'b1;
        next_data = 12'h102;
        settle();
        check("sim_push", bus.req0_rdy, 1);
        check("sim_pop", bus.mem_rd_resp_rdy, 1);
        check("sim_data", bus.resp0_data, 12'h100);
        step();
        bus.req0_val = 1'b0;
        resp_en      = 1'b0;
        settle();
        check("sim_out2", outstanding, 2);
        step();
        drain(4);

        // Mid-operation reset clears state immediately and restores tie priority
        do_reset();
        bus.req0_val  = 1'b1;
        bus.req0_addr = 8'd4;
        for (int i = 0; i < 3; i++) begin
            next_data = DW'(12'h300 + i);
            settle();
            step();
        end
        bus.req0_val = 1'b0;
        resp_en      = 1'b1;
        rst          = 1'b0;
        model_reset();
        drive_table();
        #1;
        check("mid_out0", outstanding, 0);
        check("mid_mem_resp_rdy", bus.mem_rd_resp_rdy, 0);
        @(posedge clk);
        @(negedge clk);
        rst           = 1'b1;
        bus.req0_val  = 1'b1;
        bus.req0_addr = 8'h11;
        bus.req1_val  = 1'b1;
        bus.req1_addr = 8'h22;
        resp_en       = 1'b0;
        next_data     = 12'h3AB;
        settle();
        check("mid_tie_addr", bus.mem_rd_req_addr, 8'h11);
        check("mid_tie_rdy0", bus.req0_rdy, 1);
        step();
        drain(3);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.req0_val       = ($urandom_range(99) < 70);
            bus.req1_val       = ($urandom_range(99) < 70);
            bus.req0_addr      = FW'($urandom);
            bus.req1_addr      = FW'($urandom);
            bus.mem_rd_req_rdy = ($urandom_range(99) < 75);
            bus.resp0_rdy      = ($urandom_range(99) < 75);
            bus.resp1_rdy      = ($urandom_range(99) < 75);
            resp_en            = ($urandom_range(99) < 60);
            next_data          = DW'($urandom);
            settle();
            step();
        end
        drain(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
